// File: rtl/fpdiv.sv
// Goldschmidt mantissa divider datapath: one shared 27x27 multiplier and
// three Q1.26 registers (A = quotient, B = scaled divisor, C = 2 - B).
// Sequencing is entirely host-driven through the mux selects and enables.
module fpdiv (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inputNum,
    input  logic [31:0] inputDenom,
    input  logic        en_a,
    input  logic        en_b,
    input  logic        sel_mux2,
    input  logic [1:0]  sel_mux4,
    output logic [26:0] out,
    output logic [26:0] tb_rega,
    output logic [26:0] tb_regb,
    output logic [26:0] tb_regc
);

    localparam int unsigned W       = 27;
    localparam int unsigned PW      = 2 * W;
    localparam int unsigned ROM_N   = 16;
    localparam int unsigned ROM_W   = ROM_N * W;
    localparam int unsigned FRAC    = 26;

    // Reciprocal seed table: IA[k] = floor(2^26 / (1 + (2k+1)/32)) = floor(2^31 / (33 + 2k))
    function automatic logic [ROM_W-1:0] f_build_rom();
        logic [ROM_W-1:0] rom;
        rom = '0;
        for (int k = 0; k < int'(ROM_N); k++) begin
            rom[k*W +: W] = W'(64'h0000_0000_8000_0000 / 64'(33 + 2 * k));
        end
        return rom;
    endfunction

    localparam logic [ROM_W-1:0] IA_ROM = f_build_rom();

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_c;

    logic [W-1:0]  w_nm;
    logic [W-1:0]  w_dm;
    logic [3:0]    w_idx;
    logic [8:0]    w_rom_base;
    logic [W-1:0]  w_ia;
    logic [W-1:0]  w_x;
    logic [W-1:0]  w_y;
    logic [PW-1:0] w_prod;
    logic [W-1:0]  w_p;
    logic          w_unused;

    // Mantissas with implicit leading one, widened to Q1.26
    assign w_nm = {1'b1, inputNum[22:0], 3'b000};
    assign w_dm = {1'b1, inputDenom[22:0], 3'b000};

    // Seed lookup indexed by the top four divisor fraction bits
    assign w_idx      = inputDenom[22:19];
    assign w_rom_base = 9'(w_idx) * 9'd27;
    assign w_ia       = IA_ROM[w_rom_base +: W];

    // Operand selection for the shared multiplier
    always_comb begin
        w_x = w_nm;
        w_y = w_ia;
        unique case (sel_mux4)
            2'b00:   w_x = w_nm;
            2'b01:   w_x = w_dm;
            2'b10:   w_x = r_a;
            default: w_x = r_b;
        endcase
        w_y = sel_mux2 ? r_c : w_ia;
    end

    // Q1.26 x Q1.26 product, truncated back to Q1.26 (integer overflow bit dropped)
    assign w_prod = PW'(w_x) * PW'(w_y);
    assign w_p    = w_prod[FRAC +: W];

    // Bits intentionally discarded by the datapath
    assign w_unused = ^{w_prod[PW-1], w_prod[FRAC-1:0], inputNum[31:23], inputDenom[31:23]};

    // Register A: running quotient
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a <= '0;
        end else if (en_a) begin
            r_a <= w_p;
        end
    end

    // Registers B and C: scaled divisor and its correction factor 2 - B
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_b <= '0;
            r_c <= '0;
        end else if (en_b) begin
            r_b <= w_p;
            r_c <= ~w_p + W'(1);
        end
    end

    assign out     = r_a;
    assign tb_rega = r_a;
    assign tb_regb = r_b;
    assign tb_regc = r_c;

endmodule

// File: tb/tb_fpdiv.sv
// Directed self-checking bench for the fpdiv Goldschmidt datapath.
module tb_fpdiv;

    logic        clk;
    logic        reset;
    logic [31:0] inputNum;
    logic [31:0] inputDenom;
    logic        en_a;
    logic        en_b;
    logic        sel_mux2;
    logic [1:0]  sel_mux4;
    logic [26:0] out;
    logic [26:0] tb_rega;
    logic [26:0] tb_regb;
    logic [26:0] tb_regc;

    int n_cmp;
    int n_err;

    localparam logic [26:0] ONE      = 27'h4000000;
    localparam logic [26:0] ONE_HALF = 27'h6000000;
    localparam logic [26:0] TWO_3RD  = 27'h2AAAAAA;
    localparam logic [26:0] IA0      = 27'h3E0F83E;
    localparam logic [26:0] C0       = 27'h41F07C2;
    localparam logic [26:0] IA8      = 27'h29CBC14;
    localparam logic [26:0] A_N15    = 27'h5D1745D;

    fpdiv dut (
        .clk        (clk),
        .reset      (reset),
        .inputNum   (inputNum),
        .inputDenom (inputDenom),
        .en_a       (en_a),
        .en_b       (en_b),
        .sel_mux2   (sel_mux2),
        .sel_mux4   (sel_mux4),
        .out        (out),
        .tb_rega    (tb_rega),
        .tb_regb    (tb_regb),
        .tb_regc    (tb_regc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [26:0] obs, input logic [26:0] exp,
                              input int tol);
        int diff;
        diff = int'(obs) - int'(exp);
        if (diff < 0) diff = -diff;
        n_cmp++;
        assert (!$isunknown(obs) && diff <= tol) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h tol=%0d", tag, obs, exp, tol);
        end
    endtask

    // One clocked step; inputs change 1 time unit after the edge
    task automatic do_step(input logic [1:0] m4, input logic m2, input logic ea, input logic eb);
        sel_mux4 = m4;
        sel_mux2 = m2;
        en_a     = ea;
        en_b     = eb;
        @(posedge clk);
        #1;
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    // Full Goldschmidt sequence: seed steps plus six iterations
    task automatic run_seq(input logic [31:0] num, input logic [31:0] den);
        inputNum   = num;
        inputDenom = den;
        do_step(2'b00, 1'b0, 1'b1, 1'b0);
        do_step(2'b01, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            do_step(2'b10, 1'b1, 1'b1, 1'b0);
            do_step(2'b11, 1'b1, 1'b0, 1'b1);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        inputNum   = 32'h0;
        inputDenom = 32'h0;
        en_a       = 1'b0;
        en_b       = 1'b0;
        sel_mux2   = 1'b0;
        sel_mux4   = 2'b00;

        // Reset state
        #2;
        check("rst_out", out, 27'h0);
        check("rst_a", tb_rega, 27'h0);
        check("rst_b", tb_regb, 27'h0);
        check("rst_c", tb_regc, 27'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // N = D = 1.0: seed steps
        do_step(2'b00, 1'b0, 1'b1, 1'b0);
        check("s1_a", tb_rega, IA0);
        check("s1_b_hold", tb_regb, 27'h0);
        do_step(2'b01, 1'b0, 1'b0, 1'b1);
        check("s2_b", tb_regb, IA0);
        check("s2_c", tb_regc, C0);
        check("s2_a_hold", tb_rega, IA0);

        // N = D = 1.0: full sequence
        run_seq(32'h0, 32'h0);
        check_near("n1d1_out", out, ONE, 8);
        check_near("n1d1_b", tb_regb, ONE, 8);
        check("n1d1_a_eq_b", tb_rega, tb_regb);

        // Mid-sequence asynchronous reset, checked before the next edge
        #2;
        reset = 1'b1;
        #1;
        check("mrst_out", out, 27'h0);
        check("mrst_a", tb_rega, 27'h0);
        check("mrst_b", tb_regb, 27'h0);
        check("mrst_c", tb_regc, 27'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // N = 1.5, D = 1.0: first load after reset, then hold behaviour
        inputNum   = 32'h0040_0000;
        inputDenom = 32'h0;
        do_step(2'b00, 1'b0, 1'b1, 1'b0);
        check("n15_s1_a", tb_rega, A_N15);
        do_step(2'b01, 1'b0, 1'b0, 1'b1);
        check("n15_s2_b", tb_regb, IA0);
        check("n15_s2_c", tb_regc, C0);
        for (int i = 0; i < 5; i++) begin
            do_step(2'(i), 1'(i), 1'b0, 1'b0);
        end
        check("hold_a", tb_rega, A_N15);
        check("hold_b", tb_regb, IA0);
        check("hold_c", tb_regc, C0);

        // N = 1.5, D = 1.0: full sequence
        run_seq(32'h0040_0000, 32'h0);
        check_near("n15d1_out", out, ONE_HALF, 8);
        check_near("n15d1_b", tb_regb, ONE, 8);

        // D = 1.5 exercises a different seed entry, N = 1.0
        inputNum   = 32'h0;
        inputDenom = 32'h0040_0000;
        do_step(2'b00, 1'b0, 1'b1, 1'b0);
        check("ia8_a", tb_rega, IA8);
        run_seq(32'h0, 32'h0040_0000);
        check_near("n1d15_out", out, TWO_3RD, 8);

        // Both enables together on the same product
        inputNum   = 32'h0;
        inputDenom = 32'h0;
        do_step(2'b00, 1'b0, 1'b1, 1'b1);
        check("both_a", tb_rega, IA0);
        check("both_b", tb_regb, IA0);
        check("both_c", tb_regc, C0);

        // Bits [31:23] of the inputs must not matter
        inputNum   = 32'hFF80_0000;
        inputDenom = 32'hFF80_0000;
        do_step(2'b01, 1'b0, 1'b1, 1'b0);
        check("hibits_a", tb_rega, IA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpdiv.md
FPDIV -- requirements
Module: fpdiv

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all registers update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 inputNum  input  32  numerator; bits [22:0] are the mantissa fraction, bits [31:23] are ignored.
REQ-005 inputDenom  input  32  denominator; same format as inputNum.
REQ-006 en_a  input  1  load enable for register A.
REQ-007 en_b  input  1  load enable for registers B and C.
REQ-008 out  output  27  quotient, equal to register A.
REQ-009 tb_rega  output  27  debug copy of register A.
REQ-010 tb_regb  output  27  debug copy of register B.
REQ-011 tb_regc  output  27  debug copy of register C.
REQ-012 sel_mux2  input  1  multiplier operand select: 0 = IA, 1 = register C.
REQ-013 sel_mux4  input  2  multiplicand select: 00 = Nm, 01 = Dm, 10 = register A, 11 = register B.

Function
REQ-014 Internal format SHALL be unsigned Q1.26 over 27 bits: bit 26 is the integer bit, bits [25:0] are fraction, so 1.0 = 0x4000000.
REQ-015 Mantissas SHALL be Nm = {1'b1, inputNum[22:0], 3'b000} and Dm = {1'b1, inputDenom[22:0], 3'b000}.
REQ-016 Initial approximation IA SHALL come from a 16-entry constant ROM indexed by k = inputDenom[22:19]: IA[k] = floor(2^26 / (1 + (2k+1)/32)), a combinational lookup.
  - Example: IA[0] = 0x3E0F83E.
REQ-017 One 27x27 unsigned multiplier SHALL form X*Y; the product is P = bits [52:26] of the 54-bit result, truncated with no rounding; bit 53 is discarded.
  - X = the sel_mux4 choice; Y = the sel_mux2 choice.
  - The multiplier and muxes SHALL be combinational.
REQ-018 On a rising clk with en_a=1, register A SHALL load P.
REQ-019 On a rising clk with en_b=1:
  - register B SHALL load P;
  - register C SHALL load (2^27 - P) mod 2^27, i.e. 2.0 - P as a 27-bit two's complement.
REQ-020 With en_a=1 and en_b=1 together, A, B and C SHALL all load from the same P on that edge.
REQ-021 A register whose enable is low SHALL hold its value.
REQ-022 Goldschmidt sequence, one step per cycle; each iteration is two cycles:
  - mux4=00, mux2=0, en_a → A = N*IA;
  - mux4=01, mux2=0, en_b → B = D*IA, C = 2 - B;
  - per iteration: mux4=10, mux2=1, en_a → A = A*C; then mux4=11, mux2=1, en_b → B = B*C, C = 2 - B.
REQ-023 After 6 iterations, out SHALL approximate Nm/Dm to within 8 LSB in Q1.26 (truncation error only).
REQ-024 The block SHALL have no state machine; control is fully external, and sequencing by the host is not checked.

Reset
REQ-025 While reset=1, registers A, B and C SHALL be 0 immediately, independent of clk, so out = tb_rega = tb_regb = tb_regc = 0.
REQ-026 Reset asserted mid-sequence SHALL clear all registers; after release the host must restart from the mux4=00 step.
REQ-027 After reset is released, the first rising clk with an enable high SHALL load normally.

Verification
REQ-028 Assert reset with registers nonzero → all four 27-bit outputs read 0 before the next clk edge.
REQ-029 inputNum = inputDenom = 0 (N = D = 1.0), step 1 → A = 0x3E0F83E; step 2 → B = 0x3E0F83E, C = 0x41F07C2.
REQ-030 Same inputs, full 6-iteration sequence → out within 8 LSB of 0x4000000; B converges toward 0x4000000.
REQ-031 inputNum = 0x00400000 (N = 1.5), inputDenom = 0 → after 6 iterations, out within 8 LSB of 0x6000000.
REQ-032 en_a = en_b = 0 for 5 cycles while sel_mux4 and sel_mux2 toggle → A, B and C unchanged.
REQ-033 en_a = en_b = 1 with mux4=00, mux2=0, N = D = 1.0 → A = B = 0x3E0F83E, C = 0x41F07C2 on the same edge.
